// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
// Multi-cycle controller for an 8-register file (R1-R4, T1-T4). It accepts one
// command over a valid/ready handshake and expands it into per-cycle control
// words. The commands are clear, load-immediate, repeated increment/decrement,
// move and swap. Completion is signalled with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (accept on valid && ready)
//   cmd_op/dst/src/imm/cnt   command fields
//   busy, done, err          status (done/err are one-cycle pulses)
//   rf_funsel, rf_rsel,      register-file control word, all registered
//   rf_tsel, rf_o1sel,
//   rf_o2sel, rf_i
//   rf_o1, rf_o2             register-file read data
//
// Register code: 000-011 = T1-T4, 100-111 = R1-R4.
module regfile_op_sequencer #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [2:0]    cmd_dst,
  input  logic [2:0]    cmd_src,
  input  logic [DW-1:0] cmd_imm,
  input  logic [CW-1:0] cmd_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    rf_funsel,
  output logic [3:0]    rf_rsel,
  output logic [3:0]    rf_tsel,
  output logic [2:0]    rf_o1sel,
  output logic [2:0]    rf_o2sel,
  output logic [DW-1:0] rf_i,
  input  logic [DW-1:0] rf_o1,
  input  logic [DW-1:0] rf_o2
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_READ = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [2:0]    dst_q, dst_d;
  logic [2:0]    src_q, src_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    funsel_q, funsel_d;
  logic [3:0]    rsel_q, rsel_d;
  logic [3:0]    tsel_q, tsel_d;
  logic [2:0]    o1sel_q, o1sel_d;
  logic [2:0]    o2sel_q, o2sel_d;
  logic [DW-1:0] rfi_q, rfi_d;

  // R-bank enable for a register code: R1 (100) maps to bit 3, R4 (111) to bit 0.
  function automatic logic [3:0] r_enable(input logic [2:0] code);
    logic [3:0] en;
    if (code[2]) en = 4'b1000 >> code[1:0];
    else         en = 4'b0000;
    return en;
  endfunction

  // T-bank enable for a register code: T1 (000) maps to bit 3, T4 (011) to bit 0.
  function automatic logic [3:0] t_enable(input logic [2:0] code);
    logic [3:0] en;
    if (!code[2]) en = 4'b1000 >> code[1:0];
    else          en = 4'b0000;
    return en;
  endfunction

  // Next state, command latches and read-data capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          src_d = cmd_src;
          imm_d = cmd_imm;
          case (cmd_op)
            OP_CLR, OP_LDI: begin
              cnt_d   = CW'(1);
              state_d = ST_EXEC;
            end
            OP_INC, OP_DEC: begin
              cnt_d = cmd_cnt;
              // A zero repeat count issues no writes at all.
              if (cmd_cnt == {CW{1'b0}}) state_d = ST_DONE;
              else                       state_d = ST_EXEC;
            end
            OP_MOV, OP_SWAP: state_d = ST_READ;
            OP_NOP:          state_d = ST_DONE;
            default:         state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_DONE;
        else                 state_d = ST_EXEC;
      end
      ST_READ: begin
        // O1 carries src and O2 carries dst during this cycle.
        a_d     = rf_o1;
        b_d     = rf_o2;
        state_d = ST_WR1;
      end
      ST_WR1: begin
        if (op_q == OP_SWAP) state_d = ST_WR2;
        else                 state_d = ST_DONE;
      end
      ST_WR2:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs for the upcoming state, computed from the next-cycle latches.
  always_comb begin
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = 1'b0;
    err_d    = 1'b0;
    funsel_d = 2'b00;
    rsel_d   = 4'b0000;
    tsel_d   = 4'b0000;
    o1sel_d  = o1sel_q;
    o2sel_d  = o2sel_q;
    rfi_d    = {DW{1'b0}};
    case (state_d)
      ST_EXEC: begin
        rsel_d = r_enable(dst_d);
        tsel_d = t_enable(dst_d);
        case (op_d)
          OP_CLR:  funsel_d = 2'b00;
          OP_LDI: begin
            funsel_d = 2'b01;
            rfi_d    = imm_d;
          end
          OP_INC:  funsel_d = 2'b11;
          OP_DEC:  funsel_d = 2'b10;
          default: funsel_d = 2'b00;
        endcase
      end
      ST_READ: begin
        o1sel_d = src_d;
        o2sel_d = dst_d;
      end
      ST_WR1: begin
        funsel_d = 2'b01;
        rfi_d    = a_d;
        rsel_d   = r_enable(dst_d);
        tsel_d   = t_enable(dst_d);
      end
      ST_WR2: begin
        funsel_d = 2'b01;
        rfi_d    = b_d;
        rsel_d   = r_enable(src_d);
        tsel_d   = t_enable(src_d);
      end
      ST_DONE: begin
        done_d = 1'b1;
        err_d  = (op_d == OP_ILL);
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State, latches and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'b000;
      dst_q    <= 3'b000;
      src_q    <= 3'b000;
      imm_q    <= {DW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      a_q      <= {DW{1'b0}};
      b_q      <= {DW{1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      funsel_q <= 2'b00;
      rsel_q   <= 4'b0000;
      tsel_q   <= 4'b0000;
      o1sel_q  <= 3'b000;
      o2sel_q  <= 3'b000;
      rfi_q    <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      funsel_q <= funsel_d;
      rsel_q   <= rsel_d;
      tsel_q   <= tsel_d;
      o1sel_q  <= o1sel_d;
      o2sel_q  <= o2sel_d;
      rfi_q    <= rfi_d;
    end
  end

  // Ready is held low for as long as reset is asserted.
  assign cmd_ready = ready_q & ~rst;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rf_funsel = funsel_q;
  assign rf_rsel   = rsel_q;
  assign rf_tsel   = tsel_q;
  assign rf_o1sel  = o1sel_q;
  assign rf_o2sel  = o2sel_q;
  assign rf_i      = rfi_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench for regfile_op_sequencer. A behavioural register file
// responds to the control word. A command-level model predicts the latency,
// the write pattern and the final register contents; those predictions are
// queued at issue and popped when the DUT answers.
module tb_regfile_op_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [2:0] T1 = 3'b000, T2 = 3'b001, T3 = 3'b010, T4 = 3'b011;
  localparam logic [2:0] R1 = 3'b100, R2 = 3'b101, R3 = 3'b110, R4 = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op, cmd_dst, cmd_src;
  logic [DW-1:0] cmd_imm;
  logic [CW-1:0] cmd_cnt;
  logic          busy, done, err;
  logic [1:0]    rf_funsel;
  logic [3:0]    rf_rsel, rf_tsel;
  logic [2:0]    rf_o1sel, rf_o2sel;
  logic [DW-1:0] rf_i, rf_o1, rf_o2;

  logic [7:0] regs     [0:7] = '{default: 8'h00};
  logic [7:0] exp_regs [0:7] = '{default: 8'h00};

  typedef struct {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
    int         lat;
    int         writes;
    logic       err;
    logic [1:0] fs;
    logic [7:0] en1;
    logic [7:0] en2;
    logic       chk_data;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] src_old;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
    .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
    .busy(busy), .done(done), .err(err),
    .rf_funsel(rf_funsel), .rf_rsel(rf_rsel), .rf_tsel(rf_tsel),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_i(rf_i),
    .rf_o1(rf_o1), .rf_o2(rf_o2)
  );

  // Register file model: index 0-3 = T1-T4, 4-7 = R1-R4; reads are combinational.
  assign rf_o1 = regs[rf_o1sel];
  assign rf_o2 = regs[rf_o2sel];

  function automatic logic [7:0] rf_apply(input logic [7:0] v, input logic [1:0] fs,
                                          input logic [7:0] din);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return 8'(v - 8'd1);
      default: return 8'(v + 8'd1);
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_tsel[3-i]) regs[i]   <= rf_apply(regs[i], rf_funsel, rf_i);
      if (rf_rsel[3-i]) regs[4+i] <= rf_apply(regs[4+i], rf_funsel, rf_i);
    end
  end

  // Expected {rsel,tsel} for a register code.
  function automatic logic [7:0] en_of(input logic [2:0] code);
    logic [7:0] e;
    e = 8'h00;
    case (code)
      T1: e = 8'b0000_1000;
      T2: e = 8'b0000_0100;
      T3: e = 8'b0000_0010;
      T4: e = 8'b0000_0001;
      R1: e = 8'b1000_0000;
      R2: e = 8'b0100_0000;
      R3: e = 8'b0010_0000;
      default: e = 8'b0001_0000;
    endcase
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Issue one command (called at a negedge) and check it through to completion.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic [3:0] cnt);
    exp_t e;
    exp_t got;
    int waitn;
    int lat;
    int wr;
    logic [7:0] en;
    logic [7:0] dst_old;
    waitn = 0;
    while (cmd_ready !== 1'b1 && waitn < 50) begin
      @(negedge clk);
      waitn++;
    end
    check_eq("ready_before_issue", 32'(cmd_ready), 32'd1);

    dst_old    = exp_regs[dst];
    e.op       = op;
    e.dst      = dst;
    e.src      = src;
    e.src_old  = exp_regs[src];
    e.lat      = 1;
    e.writes   = 0;
    e.err      = 1'b0;
    e.fs       = 2'b00;
    e.en1      = en_of(dst);
    e.en2      = en_of(dst);
    e.chk_data = 1'b0;
    e.d1       = 8'h00;
    e.d2       = 8'h00;
    case (op)
      OP_CLR: begin e.lat = 2; e.writes = 1; exp_regs[dst] = 8'h00; end
      OP_LDI: begin
        e.lat = 2; e.writes = 1; e.fs = 2'b01; e.chk_data = 1'b1; e.d1 = imm;
        exp_regs[dst] = imm;
      end
      OP_INC: begin
        e.lat = int'(cnt) + 1; e.writes = int'(cnt); e.fs = 2'b11;
        exp_regs[dst] = 8'(dst_old + {4'b0000, cnt});
      end
      OP_DEC: begin
        e.lat = int'(cnt) + 1; e.writes = int'(cnt); e.fs = 2'b10;
        exp_regs[dst] = 8'(dst_old - {4'b0000, cnt});
      end
      OP_MOV: begin
        e.lat = 3; e.writes = 1; e.fs = 2'b01; e.chk_data = 1'b1; e.d1 = e.src_old;
        exp_regs[dst] = e.src_old;
      end
      OP_SWAP: begin
        e.lat = 4; e.writes = 2; e.fs = 2'b01; e.chk_data = 1'b1;
        e.d1 = e.src_old; e.d2 = dst_old; e.en2 = en_of(src);
        exp_regs[dst] = e.src_old;
        exp_regs[src] = dst_old;
      end
      OP_NOP:  e.lat = 1;
      default: e.err = 1'b1;
    endcase
    sb_q.push_back(e);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    cmd_imm   = imm;
    cmd_cnt   = cnt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_dst   = 3'($urandom_range(0, 7));
    cmd_src   = 3'($urandom_range(0, 7));
    cmd_imm   = 8'($urandom_range(0, 255));
    cmd_cnt   = 4'($urandom_range(0, 15));

    got = sb_q.pop_front();
    lat = 1;
    wr  = 0;
    while (1) begin
      en = {rf_rsel, rf_tsel};
      if (en != 8'h00) begin
        check_eq("wr_enable", 32'(en), 32'((wr == 0) ? got.en1 : got.en2));
        check_eq("wr_funsel", 32'(rf_funsel), 32'(got.fs));
        if (got.chk_data) check_eq("wr_data", 32'(rf_i), 32'((wr == 0) ? got.d1 : got.d2));
        wr++;
      end
      if ((got.op == OP_MOV || got.op == OP_SWAP) && lat == 1) begin
        check_eq("read_o1sel", 32'(rf_o1sel), 32'(got.src));
        check_eq("read_o2sel", 32'(rf_o2sel), 32'(got.dst));
        check_eq("read_o1_data", 32'(rf_o1), 32'(got.src_old));
      end
      if (done === 1'b1 || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    check_eq("done_latency", 32'(lat), 32'(got.lat));
    check_eq("done_err", 32'(err), 32'(got.err));
    check_eq("busy_in_done", 32'(busy), 32'd1);
    check_eq("write_cycles", 32'(wr), 32'(got.writes));
    check_eq("reg_dst", 32'(regs[got.dst]), 32'(exp_regs[got.dst]));
    check_eq("reg_src", 32'(regs[got.src]), 32'(exp_regs[got.src]));

    @(negedge clk);
    check_eq("done_single_pulse", 32'({done, err}), 32'd0);
    check_eq("ready_after_done", 32'({cmd_ready, busy}), 32'b10);
    check_eq("funsel_idle", 32'({rf_funsel, rf_rsel, rf_tsel}), 32'd0);
    if (got.op == OP_MOV || got.op == OP_SWAP)
      check_eq("o1sel_hold", 32'(rf_o1sel), 32'(got.src));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'b000; cmd_dst = 3'b000; cmd_src = 3'b000; cmd_imm = 8'h00; cmd_cnt = 4'h0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", 32'(cmd_ready), 32'd0);
    check_eq("reset_status", 32'({busy, done, err}), 32'd0);
    check_eq("reset_ctrl", 32'({rf_funsel, rf_rsel, rf_tsel, rf_o1sel, rf_o2sel}), 32'd0);
    check_eq("reset_rf_i", 32'(rf_i), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Abort INC R1 cnt=8 after three writes.
    cmd_valid = 1'b1; cmd_op = OP_INC; cmd_dst = R1; cmd_cnt = 4'd8;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_pre_en", 32'({rf_rsel, rf_funsel, done}), 32'b1000_11_0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_enables", 32'({rf_rsel, rf_tsel}), 32'd0);
    check_eq("abort_status", 32'({busy, done, err, cmd_ready}), 32'd0);
    check_eq("abort_reg", 32'(regs[4]), 32'h03);
    exp_regs[4] = 8'h03;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", 32'(cmd_ready), 32'd1);

    run_cmd(OP_LDI, R4, T1, 8'h04, 4'd0);
    run_cmd(OP_INC, R4, T1, 8'h00, 4'd3);
    run_cmd(OP_MOV, T4, R4, 8'h00, 4'd0);   // reads R4 (0x07) through O1 with o1sel=111
    run_cmd(OP_LDI, T1, T1, 8'h02, 4'd0);
    run_cmd(OP_DEC, T1, T1, 8'h00, 4'd5);   // wraps to 0xFD
    run_cmd(OP_INC, R2, T1, 8'h00, 4'd0);
    run_cmd(OP_ILL, R2, T1, 8'h00, 4'd0);
    run_cmd(OP_LDI, T3, T1, 8'h5A, 4'd0);
    run_cmd(OP_MOV, R1, T3, 8'h00, 4'd0);
    run_cmd(OP_LDI, R3, T1, 8'h11, 4'd0);
    run_cmd(OP_LDI, T2, T1, 8'hEE, 4'd0);
    run_cmd(OP_SWAP, R3, T2, 8'h00, 4'd0);
    run_cmd(OP_SWAP, R3, R3, 8'h00, 4'd0);
    run_cmd(OP_NOP, R1, R1, 8'h00, 4'd0);
    run_cmd(OP_CLR, R1, T1, 8'h00, 4'd0);
    run_cmd(OP_INC, T4, T1, 8'h00, 4'd15);
    check_eq("dec_wrap_t1", 32'(regs[0]), 32'hFD);
    check_eq("swap_r3", 32'(regs[6]), 32'hEE);
    check_eq("swap_t2", 32'(regs[1]), 32'h11);

    for (int k = 0; k < 24; k++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle controller that drives the 8-bit R1–R4 / T1–T4 register file control inputs: FunSel, RSel, TSel, O1Sel, O2Sel and data-in.
- Accepts one command at a time over a valid/ready handshake. Expands it into per-cycle register-file control words: clear, load-immediate, repeated increment/decrement, move and swap.
- Signals completion with a one-cycle done pulse.
- Sits between the instruction/test driver and the register file; it is the only writer of register-file controls.

Parameters:
- DW, 8, data width of the register file and immediates
- CW, 4, width of the repeat-count field

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE with rst low; a command is accepted on an edge where valid&&ready
- cmd_op  in  3  000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 SWAP, 111 illegal
- cmd_dst  in  3  destination register, register code below
- cmd_src  in  3  source register (MOV/SWAP only), register code below
- cmd_imm  in  DW  immediate (LDI only)
- cmd_cnt  in  CW  repeat count (INC/DEC only)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for illegal op
- rf_funsel  out  2  00 clear, 01 load, 10 decrement, 11 increment
- rf_rsel  out  4  R enables, one-hot: bit3=R1 … bit0=R4
- rf_tsel  out  4  T enables, one-hot: bit3=T1 … bit0=T4
- rf_o1sel  out  3  O1 read select
- rf_o2sel  out  3  O2 read select
- rf_i  out  DW  register-file data input
- rf_o1  in  DW  register-file O1 output
- rf_o2  in  DW  register-file O2 output

Register code (used by cmd_dst, cmd_src, rf_o1sel, rf_o2sel):
- 000–011 = T1–T4
- 100–111 = R1–R4

Behaviour:
- All outputs are registered (Moore); the register file samples the control word at the edge ending each cycle.
- Reset: state IDLE, cmd_ready 0 while rst is high. busy, done, err = 0; rf_funsel = 00; rf_rsel = rf_tsel = 0000; rf_o1sel = rf_o2sel = 000; rf_i = 0; counter and latches = 0.
- Reset mid-operation: abort at that edge; remaining writes are not issued, and no done/err pulse occurs.
- Enables:
  - Exactly one bit of rf_rsel|rf_tsel is high in a write cycle; both are zero in every other cycle.
  - The dst code selects which bit: codes 100–111 drive rf_rsel, codes 000–011 drive rf_tsel.
- States:
  - IDLE: ready=1. On accept, latch the command, then branch:
    - CLR/LDI → EXEC, cnt=1
    - INC/DEC → EXEC with cnt=cmd_cnt; if cmd_cnt=0 → DONE directly
    - MOV/SWAP → READ
    - NOP → DONE
    - illegal → DONE with err
  - EXEC: one write per cycle to dst. funsel is 00 for CLR, 01 with rf_i=imm for LDI, 11 for INC, 10 for DEC. Counter decrements each cycle; after the cycle with counter=1 → DONE.
  - READ: rf_o1sel=src, rf_o2sel=dst, no enables. At the end of the cycle, latch a=rf_o1 and b=rf_o2. MOV → WR1; SWAP → WR1.
  - WR1: funsel=01, rf_i=a, enable dst. MOV → DONE; SWAP → WR2.
  - WR2: funsel=01, rf_i=b, enable src → DONE.
  - DONE: done=1 (and err=1 for illegal op), no enables → IDLE.
- Latency from accept edge to done high:
  - CLR/LDI: 2 cycles
  - INC/DEC: cnt+1 cycles
  - MOV: 3 cycles
  - SWAP: 4 cycles
  - NOP, illegal, INC/DEC with cnt=0: 1 cycle
- Throughput: cmd_ready returns high the cycle after done; back-to-back commands have no overlap.
- cmd_* inputs are ignored while busy.
- Edge cases:
  - MOV or SWAP with src==dst is legal and writes the same value (SWAP writes it twice).
  - Increment/decrement wrap modulo 2^DW is the register file's behaviour; the sequencer does not saturate.
- After an operation, rf_o1sel and rf_o2sel hold their last values and rf_funsel returns to 00. No enables are active, so the held funsel has no effect.

Test Plan:
- Reset: assert rst mid-INC (cnt=8, after 3 writes) → next cycle all enables 0, busy=0, no done; the register shows 3 increments. Deassert → cmd_ready=1.
- LDI R4,0x04 then INC R4 cnt=3:
  - rf_rsel=0001 for 1 cycle with funsel=01, then for 3 cycles with funsel=11.
  - R4 reads 0x07 on O1 with o1sel=111.
  - done pulses 2 and 4 cycles after the respective accepts.
- DEC T1 cnt=5 from 0x02 → rf_tsel=1000 for 5 cycles; T1 wraps to 0xFD.
- INC R2 cnt=0 → no enables, done 1 cycle after accept. Op 111 → done and err together, no writes.
- MOV R1←T3 with T3=0x5A:
  - READ cycle with o1sel=010, then WR1 with rsel=1000, rf_i=0x5A.
  - R1=0x5A; done 3 cycles after accept.
- SWAP R3,T2 with R3=0x11, T2=0xEE → after done, R3=0xEE and T2=0x11. Repeat with src==dst=R3 → value unchanged, 2 write cycles observed.
